// File: rtl/score_pkg.sv
// Shared types and constants for the score digit renderer:
// glyph geometry, BCD digit type, conversion FSM states and
// the saturation limit helper.
package score_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} conv_state_t;

  // Largest value representable in nd decimal digits (10^nd - 1).
  function automatic int max_score(input int nd);
    int m;
    m = 1;
    for (int i = 0; i < nd; i++) m = m * 10;
    return m - 1;
  endfunction

endpackage

// File: rtl/score_digit_renderer_bin2bcd.sv
// Sequential double-dabble converter. A start pulse in IDLE latches
// the (saturated) binary value; SCORE_W shift cycles follow, then a
// one-cycle COMMIT where done is high and bcd holds the final result.
// Starts while busy are ignored.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int SCORE_W    = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [SCORE_W-1:0]        bin,
  output logic                      busy,
  output logic                      done,
  output logic [4*NUM_DIGITS-1:0]   bcd
);

  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam logic [SCORE_W-1:0] SAT = SCORE_W'(max_score(NUM_DIGITS));

  conv_state_t                state;
  logic [CNT_W-1:0]           cnt;
  logic [SCORE_W-1:0]         sr_bin;
  logic [BCD_W-1:0]           sr_bcd;
  logic [BCD_W-1:0]           adj;
  logic [BCD_W+SCORE_W-1:0]   nxt;

  // Add-3 correction on every nibble >= 5, then shift {bcd, bin} left.
  always_comb begin
    adj = sr_bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (sr_bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = sr_bcd[4*i +: 4] + 4'd3;
    nxt = {adj, sr_bin} << 1;
  end

  // Conversion FSM with registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      sr_bin <= '0;
      sr_bcd <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sr_bin <= (bin > SAT) ? SAT : bin;
          sr_bcd <= '0;
          cnt    <= '0;
          busy   <= 1'b1;
          state  <= CONVERT;
        end
        CONVERT: begin
          {sr_bcd, sr_bin} <= nxt;
          if (cnt == CNT_W'(SCORE_W - 1)) begin
            done  <= 1'b1;
            state <= COMMIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        COMMIT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bcd = sr_bcd;

endmodule

// File: rtl/score_digit_renderer.sv
// Score digit renderer: latches the score at frame_start, converts it
// to BCD over SCORE_W+2 cycles, and during scan-out maps DrawX/DrawY
// to glyph ROM addresses with a 2-cycle pipelined score_on pixel flag.
// Optional: LEADING_ZERO_BLANK_EN blanks leading zero digits (the
// rightmost digit is always drawn).
module score_digit_renderer
  import score_pkg::*;
#(
  parameter int         NUM_DIGITS = 4,
  parameter int         SCORE_W    = 14,
  parameter logic [9:0] BOX_X0     = 10'd560,
  parameter logic [9:0] BOX_Y0     = 10'd16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_start,
  input  logic [SCORE_W-1:0] score,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  output logic [7:0]         rom_addr,
  input  logic [7:0]         rom_data,
  output logic               score_on,
  output logic               busy,
  output logic               digits_valid
);

  // 11-bit window bounds so BOX_X0 + width cannot wrap.
  localparam logic [10:0] X_LO = {1'b0, BOX_X0};
  localparam logic [10:0] X_HI = X_LO + 11'(GLYPH_W * NUM_DIGITS) - 11'd1;
  localparam logic [10:0] Y_LO = {1'b0, BOX_Y0};
  localparam logic [10:0] Y_HI = Y_LO + 11'(GLYPH_H - 1);

  logic                          conv_done;
  logic [4*NUM_DIGITS-1:0]       conv_bcd;
  bcd_digit_t [NUM_DIGITS-1:0]   disp;      // [NUM_DIGITS-1] is most significant

  logic       in_box, show;
  logic [9:0] dx;
  logic [2:0] col, col_q;
  logic [3:0] row;
  bcd_digit_t digit_value;
  logic       in_box_q;
`ifdef LEADING_ZERO_BLANK_EN
  logic       lz_run, blank;
`endif

  bin2bcd_seq #(.SCORE_W(SCORE_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .clk   (Clk),
    .rst   (Reset),
    .start (frame_start),
    .bin   (score),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Displayed digit bank: replaced only by a finished conversion.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      disp         <= '0;
      digits_valid <= 1'b0;
    end else if (conv_done) begin
      disp         <= conv_bcd;
      digits_valid <= 1'b1;
    end
  end

  // Stage 0: window test, digit/column/row decode, optional blanking.
  always_comb begin
    in_box = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} <= X_HI) &&
             ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} <= Y_HI);
    dx          = DrawX - BOX_X0;
    col         = dx[2:0];
    row         = DrawY[3:0] - BOX_Y0[3:0];
    digit_value = '0;
`ifdef LEADING_ZERO_BLANK_EN
    lz_run = 1'b1;
    blank  = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (in_box && dx[9:3] == 7'(i)) begin
        digit_value = disp[NUM_DIGITS-1-i];
`ifdef LEADING_ZERO_BLANK_EN
        blank = lz_run && (disp[NUM_DIGITS-1-i] == '0) && (i != NUM_DIGITS - 1);
`endif
      end
`ifdef LEADING_ZERO_BLANK_EN
      if (disp[NUM_DIGITS-1-i] != '0) lz_run = 1'b0;
`endif
    end
`ifdef LEADING_ZERO_BLANK_EN
    show = in_box & ~blank;
`else
    show = in_box;
`endif
  end

  // Stage 1: register ROM address and pixel qualifiers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr <= '0;
      col_q    <= '0;
      in_box_q <= 1'b0;
    end else begin
      rom_addr <= {digit_value, row};
      col_q    <= col;
      in_box_q <= show;
    end
  end

  // Stage 2: pick the glyph bit (bit 0 = leftmost pixel).
  always_ff @(posedge Clk) begin
    if (Reset) score_on <= 1'b0;
    else       score_on <= in_box_q & rom_data[col_q];
  end

endmodule
